// File: rtl/half_adder_pkg.sv
// Shared definitions for the half-adder checker: FSM state encoding,
// observed-vector width and a helper that packs one observed vector.
package half_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int VEC_W = 4;

    // Pack operands and observed results as {A,B,S,C}
    function automatic logic [VEC_W-1:0] pack_vec(input logic a, input logic b,
                                                  input logic s, input logic c);
        return {a, b, s, c};
    endfunction

endpackage

// File: rtl/half_adder_ref.sv
// Combinational golden model of a half adder: sum = A^B, carry = A&B.
module half_adder_ref (
    input  logic A,
    input  logic B,
    output logic S_exp,
    output logic C_exp
);

    assign S_exp = A ^ B;
    assign C_exp = A & B;

endmodule

// File: rtl/half_adder_checker.sv
// Half-adder checker: compares observed {A,B,S,C} vectors against a
// reference model over a run of NUM_VECTORS accepted vectors and reports
// pass/fail counts plus the first failing vector.
// Optional input-combination coverage tracking is enabled by defining
// HALF_ADDER_CHECKER_COV_EN (adds cov_map/all_covered, gates pass).
module half_adder_checker
    import half_adder_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             A,
    input  logic             B,
    input  logic             S,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [VEC_W-1:0] first_fail_vec
`ifdef HALF_ADDER_CHECKER_COV_EN
    ,
    output logic [3:0]       cov_map,
    output logic             all_covered
`endif
);

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_first_fail_idx;
    logic [VEC_W-1:0] r_first_fail_vec;

    logic [CNT_W-1:0] w_vec_cnt_nxt;
    logic [CNT_W-1:0] w_pass_cnt_nxt;
    logic [CNT_W-1:0] w_fail_cnt_nxt;
    logic [CNT_W-1:0] w_first_fail_idx_nxt;
    logic [VEC_W-1:0] w_first_fail_vec_nxt;
    logic             w_pass_nxt;
    logic             w_cov_ok;

    logic w_s_exp;
    logic w_c_exp;
    logic w_match;
    logic w_accept;
    logic w_start_run;
    logic w_last;

    half_adder_ref u_ref (
        .A     (A),
        .B     (B),
        .S_exp (w_s_exp),
        .C_exp (w_c_exp)
    );

    assign w_match     = (S == w_s_exp) && (C == w_c_exp);
    // Vectors count only inside a run; a start outside a run wins over any vector
    assign w_accept    = vec_valid && (r_state == CHECK);
    assign w_start_run = start && (r_state != CHECK);
    assign w_last      = w_accept && (r_vec_cnt == CNT_W'(NUM_VECTORS - 1));

`ifdef HALF_ADDER_CHECKER_COV_EN
    logic [3:0] r_cov_map;
    logic [3:0] w_cov_map_nxt;

    // Coverage map: one bit per {A,B} combination seen in an accepted vector
    always_comb begin
        w_cov_map_nxt = r_cov_map;
        if (w_start_run) begin
            w_cov_map_nxt = 4'b0000;
        end else if (w_accept) begin
            w_cov_map_nxt = r_cov_map | (4'b0001 << {A, B});
        end else begin
            w_cov_map_nxt = r_cov_map;
        end
    end

    // Coverage register, cleared on reset and at the start of each run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cov_map <= 4'b0000;
        end else begin
            r_cov_map <= w_cov_map_nxt;
        end
    end

    assign cov_map     = r_cov_map;
    assign all_covered = &r_cov_map;
    assign w_cov_ok    = &w_cov_map_nxt;
`else
    assign w_cov_ok    = 1'b1;
`endif

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = CHECK;
                else       w_state_nxt = IDLE;
            end
            CHECK: begin
                if (w_last) w_state_nxt = DONE;
                else        w_state_nxt = CHECK;
            end
            DONE: begin
                if (start) w_state_nxt = CHECK;
                else       w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter and first-failure capture next values
    always_comb begin
        w_vec_cnt_nxt        = r_vec_cnt;
        w_pass_cnt_nxt       = r_pass_cnt;
        w_fail_cnt_nxt       = r_fail_cnt;
        w_first_fail_idx_nxt = r_first_fail_idx;
        w_first_fail_vec_nxt = r_first_fail_vec;
        if (w_start_run) begin
            w_vec_cnt_nxt        = '0;
            w_pass_cnt_nxt       = '0;
            w_fail_cnt_nxt       = '0;
            w_first_fail_idx_nxt = '0;
            w_first_fail_vec_nxt = '0;
        end else if (w_accept) begin
            w_vec_cnt_nxt = sat_inc(r_vec_cnt);
            if (w_match) begin
                w_pass_cnt_nxt = sat_inc(r_pass_cnt);
            end else begin
                w_fail_cnt_nxt = sat_inc(r_fail_cnt);
                // fail_cnt saturates, so zero reliably marks "no failure yet"
                if (r_fail_cnt == '0) begin
                    w_first_fail_idx_nxt = r_vec_cnt;
                    w_first_fail_vec_nxt = pack_vec(A, B, S, C);
                end else begin
                    w_first_fail_idx_nxt = r_first_fail_idx;
                    w_first_fail_vec_nxt = r_first_fail_vec;
                end
            end
        end else begin
            w_vec_cnt_nxt = r_vec_cnt;
        end
    end

    // Verdict: cleared at run start, resolved on the edge that ends the run
    always_comb begin
        w_pass_nxt = r_pass;
        if (w_start_run) begin
            w_pass_nxt = 1'b0;
        end else if (w_last) begin
            w_pass_nxt = (w_fail_cnt_nxt == '0) && w_cov_ok;
        end else begin
            w_pass_nxt = r_pass;
        end
    end

    // State, status outputs and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_vec_cnt        <= '0;
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_first_fail_idx <= '0;
            r_first_fail_vec <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_busy           <= (w_state_nxt == CHECK);
            r_done           <= (w_state_nxt == DONE);
            r_pass           <= w_pass_nxt;
            r_vec_cnt        <= w_vec_cnt_nxt;
            r_pass_cnt       <= w_pass_cnt_nxt;
            r_fail_cnt       <= w_fail_cnt_nxt;
            r_first_fail_idx <= w_first_fail_idx_nxt;
            r_first_fail_vec <= w_first_fail_vec_nxt;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign first_fail_idx = r_first_fail_idx;
    assign first_fail_vec = r_first_fail_vec;

endmodule

// File: tb/tb_half_adder_checker.sv
// Self-checking bench for half_adder_checker using a scoreboard queue of
// expected counter values. Coverage checks compile in with
// HALF_ADDER_CHECKER_COV_EN.
module tb_half_adder_checker;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             vec_valid;
    logic             A, B, S, C;
    logic             busy, done, pass;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [3:0]       first_fail_vec;
`ifdef HALF_ADDER_CHECKER_COV_EN
    logic [3:0]       cov_map;
    logic             all_covered;
`endif

    half_adder_checker #(.NUM_VECTORS(4), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .vec_valid      (vec_valid),
        .A              (A),
        .B              (B),
        .S              (S),
        .C              (C),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_vec (first_fail_vec)
`ifdef HALF_ADDER_CHECKER_COV_EN
        ,
        .cov_map        (cov_map),
        .all_covered    (all_covered)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int fc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_pass, m_fail, m_idx, m_first_idx;
    logic [3:0] m_first_vec;
    logic [3:0] m_cov;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_idx = 0; m_first_idx = 0;
        m_first_vec = 4'b0000; m_cov = 4'b0000;
        sb_q.delete();
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_done", 32'(done), 32'd0);
        check_val("start_pcnt", 32'(pass_cnt), 32'd0);
        check_val("start_fcnt", 32'(fail_cnt), 32'd0);
    endtask

    task automatic send_vec(input logic a, input logic b, input logic s, input logic c);
        exp_t e;
        bit   ok;
        A = a; B = b; S = s; C = c;
        vec_valid = 1'b1;
        ok = (s == (a ^ b)) && (c == (a & b));
        if (ok) begin
            m_pass++;
        end else begin
            if (m_fail == 0) begin
                m_first_idx = m_idx;
                m_first_vec = {a, b, s, c};
            end
            m_fail++;
        end
        m_idx++;
        m_cov[{a, b}] = 1'b1;
        e.pc = m_pass;
        e.fc = m_fail;
        sb_q.push_back(e);
        tick();
        vec_valid = 1'b0;
        e = sb_q.pop_front();
        check_val("vec_pcnt", 32'(pass_cnt), 32'(e.pc));
        check_val("vec_fcnt", 32'(fail_cnt), 32'(e.fc));
    endtask

    task automatic send_good(input int i);
        logic [1:0] ab;
        ab = 2'(i);
        send_vec(ab[1], ab[0], ab[1] ^ ab[0], ab[1] & ab[0]);
    endtask

    task automatic check_done();
        bit exp_pass;
        exp_pass = (m_fail == 0);
`ifdef HALF_ADDER_CHECKER_COV_EN
        exp_pass = exp_pass && (&m_cov);
        check_val("cov_map", 32'(cov_map), 32'(m_cov));
        check_val("all_covered", 32'(all_covered), 32'(&m_cov));
`endif
        check_val("done", 32'(done), 32'd1);
        check_val("busy_end", 32'(busy), 32'd0);
        check_val("pass", 32'(pass), 32'(exp_pass));
        check_val("ff_idx", 32'(first_fail_idx), 32'(m_first_idx));
        check_val("ff_vec", 32'(first_fail_vec), 32'(m_first_vec));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0;
        A = 1'b0; B = 1'b0; S = 1'b0; C = 1'b0;
        model_clear();
        repeat (2) tick();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_pass", 32'(pass), 32'd0);
        check_val("rst_pcnt", 32'(pass_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // vec_valid in IDLE is ignored
        A = 1'b1; B = 1'b1; S = 1'b1; C = 1'b1; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        check_val("idle_fcnt", 32'(fail_cnt), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);

        // All four correct vectors
        start_run();
        for (int i = 0; i < 4; i++) send_good(i);
        check_done();
        check_val("s1_pcnt", 32'(pass_cnt), 32'd4);

        // vec_valid after done is ignored
        A = 1'b0; B = 1'b0; S = 1'b1; C = 1'b1; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        check_val("done_fcnt", 32'(fail_cnt), 32'd0);
        check_val("done_hold", 32'(done), 32'd1);

        // Single mismatch at index 2
        start_run();
        send_good(0);
        send_good(1);
        send_vec(1'b1, 1'b0, 1'b0, 1'b1);
        send_good(3);
        check_done();
        check_val("s2_ffvec", 32'(first_fail_vec), 32'h9);

        // Mismatches at indices 1 and 3; first capture holds
        start_run();
        send_good(0);
        send_vec(1'b0, 1'b1, 1'b0, 1'b0);
        send_good(2);
        send_vec(1'b1, 1'b1, 1'b1, 1'b1);
        check_done();
        check_val("s3_ffidx", 32'(first_fail_idx), 32'd1);
        check_val("s3_fcnt", 32'(fail_cnt), 32'd2);

        // start held during CHECK does not restart the run
        start_run();
        start = 1'b1;
        for (int i = 0; i < 3; i++) send_good(i);
        start = 1'b0;
        send_good(3);
        check_done();
        check_val("s4_pcnt", 32'(pass_cnt), 32'd4);

        // Vector coinciding with start is discarded
        start = 1'b1; vec_valid = 1'b1;
        A = 1'b1; B = 1'b1; S = 1'b0; C = 1'b0;
        tick();
        start = 1'b0; vec_valid = 1'b0;
        model_clear();
        check_val("coin_fcnt", 32'(fail_cnt), 32'd0);
        check_val("coin_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_good(i);
        check_done();

        // Asynchronous reset mid-run
        start_run();
        send_good(0);
        send_good(1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_pcnt", 32'(pass_cnt), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        model_clear();
        repeat (2) tick();
        check_val("arst_idle", 32'(busy), 32'd0);
        start_run();
        for (int i = 0; i < 4; i++) send_good(i);
        check_done();
        check_val("s5_pcnt", 32'(pass_cnt), 32'd4);

        // Four correct vectors, all A=0,B=0 (coverage incomplete when enabled)
        start_run();
        for (int i = 0; i < 4; i++) send_good(0);
        check_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/half_adder_checker.md
HALF_ADDER_CHECKER -- requirements
Module: half_adder_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 4, meaning the number of vectors checked per run (legal range 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of all counters and of the vector index.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a pulse that begins a run.
REQ-006 The block SHALL have port vec_valid, input, 1 bit: A, B, S and C form a vector to check this cycle.
REQ-007 The block SHALL have ports A, B, S and C, input, 1 bit each: the DUT operands, sum and carry under observation.
REQ-008 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: the run is complete; held until the next start.
REQ-010 The block SHALL have port pass, output, 1 bit: valid while done is high; high when fail_cnt is 0.
REQ-011 The block SHALL have ports pass_cnt and fail_cnt, output, CNT_W bits each: the counts of matching and mismatching vectors.
REQ-012 The block SHALL have port first_fail_idx, output, CNT_W bits: the index (0-based) of the first mismatching vector.
REQ-013 The block SHALL have port first_fail_vec, output, 4 bits: {A,B,S,C} of the first mismatching vector.

Function
REQ-014 The block SHALL use an FSM with states IDLE, CHECK and DONE.
REQ-015 IDLE->CHECK on start; DONE->CHECK on start; CHECK->DONE in the cycle after the NUM_VECTORS-th accepted vector; no other transitions occur.
REQ-016 On entry to CHECK, the block SHALL clear vec_cnt, pass_cnt, fail_cnt, first_fail_idx, first_fail_vec and the coverage state.
REQ-017 In CHECK, with vec_valid high, expected sum SHALL be A^B and expected carry SHALL be A&B; match means S==expected sum and C==expected carry.
REQ-018 On a match, pass_cnt SHALL increment; on a mismatch, fail_cnt SHALL increment; vec_cnt SHALL increment in both cases; results are visible one cycle after sampling.
REQ-019 On the first mismatch of a run only, the block SHALL capture first_fail_idx (the current vec_cnt) and first_fail_vec.
REQ-020 vec_valid SHALL be ignored in IDLE and DONE; start SHALL be ignored in CHECK.
REQ-021 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 busy SHALL be high exactly in CHECK, and done SHALL be high exactly in DONE; both outputs are registered.
REQ-023 A vector and start arriving in the same cycle in IDLE or DONE: the block SHALL start the run and discard the vector.

Reset
REQ-024 rst SHALL force IDLE immediately, independent of clk.
REQ-025 rst SHALL zero all outputs and counters; pass SHALL reset to 0.
REQ-026 Reset mid-run SHALL abandon the run; no partial result survives, and a new start is required.

Configuration
REQ-027 With HALF_ADDER_CHECKER_COV_EN defined, the block SHALL add output cov_map[3:0], where bit {A,B} sets when that input combination is accepted in CHECK, and output all_covered = &cov_map.
REQ-028 With HALF_ADDER_CHECKER_COV_EN defined, pass SHALL additionally require all_covered.
REQ-029 Without HALF_ADDER_CHECKER_COV_EN, the coverage ports and logic SHALL be absent, and pass SHALL be (fail_cnt==0).

Structure
REQ-030 Shared package half_adder_pkg SHALL hold the FSM state encoding (IDLE=2'd0, CHECK=2'd1, DONE=2'd2) and the localparam for the {A,B,S,C} vector width (4).
REQ-031 The expected-value model SHALL be a separate combinational sub-module, half_adder_ref (inputs A and B; outputs S_exp and C_exp), instantiated once.

Verification
REQ-032 Scenario: reset, start, then 4 correct vectors (00/0,0; 01/1,0; 10/1,0; 11/0,1) -> done=1, pass=1, pass_cnt=4, fail_cnt=0.
REQ-033 Scenario: a run with vector 2 driven as A=1,B=0,S=0,C=1 -> fail_cnt=1, first_fail_idx=2, first_fail_vec=4'b1001, pass=0.
REQ-034 Scenario: two mismatches at indices 1 and 3 -> first_fail_idx stays 1 and fail_cnt=2.
REQ-035 Scenario: vec_valid pulses in IDLE and after done, plus start held during CHECK -> counters unchanged and the run not restarted.
REQ-036 Scenario: rst asserted after 2 vectors, between clock edges -> outputs zero immediately; a new start plus 4 vectors gives pass_cnt=4.
REQ-037 Scenario (COV_EN): 4 correct vectors all with A=0,B=0 -> cov_map=4'b0001, all_covered=0, pass=0.
